// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage RISC-V pipeline: forwarding selects, load-use
// stall, taken-branch flush, and stall/flush event counters.
module hazard_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic [4:0]       Rd_D,
  input  logic             RegWriteD,
  input  logic             ResultSrcD,
  input  logic             PCSrcE,
  output logic [1:0]       ForwardA_E,
  output logic [1:0]       ForwardB_E,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned SEL_W = 2;

  logic [REG_W-1:0] rs1_e_q, rs2_e_q, rd_e_q, rd_m_q, rd_w_q;
  logic             regwrite_e_q, load_e_q, regwrite_m_q, regwrite_w_q;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             lu_c;

  // MEM result beats WB result; x0 is never a forwarding source.
  function automatic logic [SEL_W-1:0] fwd_sel(
    input logic [REG_W-1:0] rs,
    input logic [REG_W-1:0] rd_m,
    input logic             rw_m,
    input logic [REG_W-1:0] rd_w,
    input logic             rw_w
  );
    logic [SEL_W-1:0] sel;
    sel = 2'b00;
    if (rw_m && (rd_m != '0) && (rd_m == rs)) begin
      sel = 2'b10;
    end else if (rw_w && (rd_w != '0) && (rd_w == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    lu_c       = 1'b0;
    ForwardA_E = 2'b00;
    ForwardB_E = 2'b00;
    StallF     = 1'b0;
    StallD     = 1'b0;
    FlushD     = 1'b0;
    FlushE     = 1'b0;

    lu_c       = load_e_q && (rd_e_q != '0) && ((rd_e_q == Rs1_D) || (rd_e_q == Rs2_D));
    ForwardA_E = fwd_sel(rs1_e_q, rd_m_q, regwrite_m_q, rd_w_q, regwrite_w_q);
    ForwardB_E = fwd_sel(rs2_e_q, rd_m_q, regwrite_m_q, rd_w_q, regwrite_w_q);
    // A taken branch squashes the decode instruction, so it overrides the stall.
    StallF     = lu_c && !PCSrcE;
    StallD     = lu_c && !PCSrcE;
    FlushD     = PCSrcE;
    FlushE     = lu_c || PCSrcE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rs1_e_q      <= '0;
      rs2_e_q      <= '0;
      rd_e_q       <= '0;
      regwrite_e_q <= 1'b0;
      load_e_q     <= 1'b0;
      rd_m_q       <= '0;
      regwrite_m_q <= 1'b0;
      rd_w_q       <= '0;
      regwrite_w_q <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      rd_w_q       <= rd_m_q;
      regwrite_w_q <= regwrite_m_q;
      rd_m_q       <= rd_e_q;
      regwrite_m_q <= regwrite_e_q;
      if (FlushE) begin
        rs1_e_q      <= '0;
        rs2_e_q      <= '0;
        rd_e_q       <= '0;
        regwrite_e_q <= 1'b0;
        load_e_q     <= 1'b0;
      end else begin
        rs1_e_q      <= Rs1_D;
        rs2_e_q      <= Rs2_D;
        rd_e_q       <= Rd_D;
        regwrite_e_q <= RegWriteD;
        load_e_q     <= ResultSrcD;
      end
      if (StallD) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (FlushD) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed scenarios with fixed expectations plus random
// traffic checked against a queue-of-slots pipeline model.
module tb_hazard_unit;

  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rst;
  logic [4:0]       Rs1_D, Rs2_D, Rd_D;
  logic             RegWriteD, ResultSrcD, PCSrcE;
  logic [1:0]       ForwardA_E, ForwardB_E;
  logic             StallF, StallD, FlushD, FlushE;
  logic [CNT_W-1:0] StallCount, FlushCount;

  int checks;
  int failures;

  hazard_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rd_D(Rd_D),
    .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .PCSrcE(PCSrcE),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB instruction records.
  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rw;
    logic       ld;
  } instr_t;

  instr_t     pipe [3];
  logic [3:0] m_stalls;
  logic [3:0] m_flushes;

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    for (int s = 1; s <= 2; s++) begin
      if (pipe[s].rw && pipe[s].rd != 5'd0 && pipe[s].rd == rs)
        return (s == 1) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  function automatic logic m_lu();
    return pipe[0].ld && pipe[0].rd != 5'd0 && (pipe[0].rd == Rs1_D || pipe[0].rd == Rs2_D);
  endfunction

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic rw, input logic ld, input logic br);
    Rs1_D = rs1; Rs2_D = rs2; Rd_D = rd; RegWriteD = rw; ResultSrcD = ld; PCSrcE = br;
  endtask

  // Advance one clock, moving the model the same way the real pipeline moves.
  task automatic tick();
    logic   lu;
    instr_t dec;
    lu  = m_lu();
    dec = '{rs1: Rs1_D, rs2: Rs2_D, rd: Rd_D, rw: RegWriteD, ld: ResultSrcD};
    @(posedge clk);
    if (rst) begin
      for (int s = 0; s < 3; s++) pipe[s] = '0;
      m_stalls  = '0;
      m_flushes = '0;
    end else begin
      if (lu && !PCSrcE) m_stalls = m_stalls + 4'd1;
      if (PCSrcE) m_flushes = m_flushes + 4'd1;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = (lu || PCSrcE) ? instr_t'('0) : dec;
    end
    #1;
  endtask

  task automatic idle(input int n);
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      tick();
      @(negedge clk);
      checks++;
      if (ForwardA_E !== 2'b00 || ForwardB_E !== 2'b00) begin
        failures++;
        $display("FAIL reset_fwd: got A=%b B=%b want 00/00", ForwardA_E, ForwardB_E);
      end
      checks++;
      if (StallD !== 1'b0 || StallF !== 1'b0 || FlushE !== PCSrcE || FlushD !== PCSrcE) begin
        failures++;
        $display("FAIL reset_ctl: got StallD=%b StallF=%b FlushD=%b FlushE=%b want 0/0/%b/%b",
                 StallD, StallF, FlushD, FlushE, PCSrcE, PCSrcE);
      end
      checks++;
      if (StallCount !== 4'd0 || FlushCount !== 4'd0) begin
        failures++;
        $display("FAIL reset_cnt: got stall=%0d flush=%0d want 0/0", StallCount, FlushCount);
      end
    end
    rst = 1'b0;
    idle(1);
    drive(5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)), 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (ForwardA_E !== 2'b00 || ForwardB_E !== 2'b00 || StallD !== 1'b0 || FlushE !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got A=%b B=%b StallD=%b FlushE=%b want 00 00 0 0",
               ForwardA_E, ForwardB_E, StallD, FlushE);
    end
    tick();
  endtask

  task automatic test_alu_chain();
    idle(3);
    drive(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0); tick();
    drive(5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0); tick();
    idle(0);
    @(negedge clk);
    checks++;
    if (ForwardA_E !== 2'b10 || ForwardB_E !== 2'b00) begin
      failures++;
      $display("FAIL alu_back_to_back: got A=%b B=%b want 10 00", ForwardA_E, ForwardB_E);
    end
    idle(3);
    drive(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0); tick();
    idle(1);
    drive(5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0); tick();
    idle(0);
    @(negedge clk);
    checks++;
    if (ForwardA_E !== 2'b01) begin
      failures++;
      $display("FAIL alu_gap1: got A=%b want 01", ForwardA_E);
    end
    idle(3);
    drive(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0); tick();
    idle(2);
    drive(5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0); tick();
    idle(0);
    @(negedge clk);
    checks++;
    if (ForwardA_E !== 2'b00) begin
      failures++;
      $display("FAIL alu_gap2: got A=%b want 00", ForwardA_E);
    end
    idle(3);
    drive(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0); tick();
    drive(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0); tick();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0); tick();
    @(negedge clk);
    checks++;
    if (ForwardA_E !== 2'b00 || ForwardB_E !== 2'b00) begin
      failures++;
      $display("FAIL alu_x0: got A=%b B=%b want 00 00", ForwardA_E, ForwardB_E);
    end
  endtask

  task automatic test_mem_priority();
    idle(3);
    drive(5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0); tick();
    drive(5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0); tick();
    drive(5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0); tick();
    idle(0);
    @(negedge clk);
    checks++;
    if (ForwardB_E !== 2'b10 || ForwardA_E !== 2'b00) begin
      failures++;
      $display("FAIL mem_priority: got A=%b B=%b want 00 10", ForwardA_E, ForwardB_E);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    idle(3);
    drive(5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0); tick();
    drive(5'd0, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (StallF !== 1'b1 || StallD !== 1'b1 || FlushE !== 1'b1 || FlushD !== 1'b0 || StallCount !== 4'd0) begin
      failures++;
      $display("FAIL load_use_detect: got StallF=%b StallD=%b FlushE=%b FlushD=%b cnt=%0d want 1 1 1 0 0",
               StallF, StallD, FlushE, FlushD, StallCount);
    end
    tick();
    @(negedge clk);
    checks++;
    if (StallD !== 1'b0 || StallF !== 1'b0 || FlushE !== 1'b0 || StallCount !== 4'd1) begin
      failures++;
      $display("FAIL load_use_one_cycle: got StallD=%b StallF=%b FlushE=%b cnt=%0d want 0 0 0 1",
               StallD, StallF, FlushE, StallCount);
    end
    tick();
    idle(0);
    @(negedge clk);
    checks++;
    if (ForwardB_E !== 2'b01 || StallCount !== 4'd1) begin
      failures++;
      $display("FAIL load_use_fwd: got B=%b cnt=%0d want 01 1", ForwardB_E, StallCount);
    end
  endtask

  task automatic test_branch_vs_stall();
    do_reset();
    idle(3);
    drive(5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0); tick();
    drive(5'd0, 5'd3, 5'd9, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (StallD !== 1'b0 || StallF !== 1'b0 || FlushD !== 1'b1 || FlushE !== 1'b1) begin
      failures++;
      $display("FAIL branch_wins: got StallD=%b StallF=%b FlushD=%b FlushE=%b want 0 0 1 1",
               StallD, StallF, FlushD, FlushE);
    end
    tick();
    idle(0);
    @(negedge clk);
    checks++;
    if (FlushCount !== 4'd1 || StallCount !== 4'd0 || ForwardB_E !== 2'b00) begin
      failures++;
      $display("FAIL branch_counts: got flush=%0d stall=%0d B=%b want 1 0 00",
               FlushCount, StallCount, ForwardB_E);
    end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) tick();
    @(negedge clk);
    checks++;
    if (FlushCount !== 4'd1) begin
      failures++;
      $display("FAIL flush_wrap: got %0d want 1", FlushCount);
    end
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(0);
    @(negedge clk);
    checks++;
    if (FlushCount !== 4'd0 || StallCount !== 4'd0) begin
      failures++;
      $display("FAIL mid_reset: got flush=%0d stall=%0d want 0 0", FlushCount, StallCount);
    end
  endtask

  task automatic test_random();
    logic rw;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      rw  = 1'($urandom);
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            rw, rw && ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
      @(negedge clk);
      checks++;
      if (ForwardA_E !== m_fwd(pipe[0].rs1) || ForwardB_E !== m_fwd(pipe[0].rs2)) begin
        failures++;
        $display("FAIL rand_fwd cyc %0d: got A=%b B=%b want %b %b", i,
                 ForwardA_E, ForwardB_E, m_fwd(pipe[0].rs1), m_fwd(pipe[0].rs2));
      end
      checks++;
      if (StallD !== (m_lu() && !PCSrcE) || StallF !== (m_lu() && !PCSrcE) ||
          FlushD !== PCSrcE || FlushE !== (m_lu() || PCSrcE)) begin
        failures++;
        $display("FAIL rand_ctl cyc %0d: got StallF=%b StallD=%b FlushD=%b FlushE=%b want %b %b %b %b",
                 i, StallF, StallD, FlushD, FlushE, m_lu() && !PCSrcE, m_lu() && !PCSrcE,
                 PCSrcE, m_lu() || PCSrcE);
      end
      checks++;
      if (StallCount !== m_stalls || FlushCount !== m_flushes) begin
        failures++;
        $display("FAIL rand_cnt cyc %0d: got stall=%0d flush=%0d want %0d %0d", i,
                 StallCount, FlushCount, m_stalls, m_flushes);
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    m_stalls  = '0;
    m_flushes = '0;
    for (int s = 0; s < 3; s++) pipe[s] = '0;
    rst = 1'b1;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_alu_chain();
    test_mem_priority();
    test_load_use();
    test_branch_vs_stall();
    test_counter_wrap();
    do_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
